// File: rtl/sram_like_responder.sv
// Memory-side responder for the SRAM-like bus: in-order, fixed-latency responses from an internal word memory.
// Optional SRAM_LIKE_RANDOM_DELAY_EN adds LFSR-driven accept gating and 0-3 extra response cycles.
module sram_like_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CD_W  = $clog2(LATENCY + 3) + 1;

  logic [31:0]       mem [2**ADDR_W];
  logic [31:0]       q_data [DEPTH];
  logic [CD_W-1:0]   q_cd [DEPTH];
  logic [DEPTH-1:0]  q_vld;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] word_idx;
  logic [CD_W-1:0]   init_cd;
  logic              accept;
  logic              retire;
  logic              accept_gate;
  logic              unused_bits;

  // Byte offset, high address bits and transfer size have no effect on the memory.
  assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_W+2]};
  assign word_idx    = addr[ADDR_W+1:2];

`ifdef SRAM_LIKE_RANDOM_DELAY_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  assign accept_gate = lfsr[0];
  assign init_cd     = CD_W'(LATENCY - 1) + CD_W'(lfsr[2:1]);
`else
  assign accept_gate = 1'b1;
  assign init_cd     = CD_W'(LATENCY - 1);
`endif

  // Slot availability uses only the registered count; a same-cycle retire does not free a slot.
  assign addr_ok = !reset && (count < CNT_W'(DEPTH)) && accept_gate;
  assign accept  = req && addr_ok;

  assign data_ok = !reset && q_vld[rd_ptr] && (q_cd[rd_ptr] == '0);
  assign retire  = data_ok;
  assign rdata   = data_ok ? q_data[rd_ptr] : 32'h0;

  // Memory: byte-enabled write at the accept edge, never cleared by reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Queue payload and countdowns; validity lives in q_vld, so these need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (q_vld[i] && (q_cd[i] != '0)) begin
        q_cd[i] <= q_cd[i] - CD_W'(1);
      end
    end
    if (accept) begin
      q_data[wr_ptr] <= wr ? 32'h0 : mem[word_idx];
      q_cd[wr_ptr]   <= init_cd;
    end
  end

  // Queue control: pointers, valid flags and outstanding count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
    end else begin
      if (retire) begin
        q_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (accept) begin
        q_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_like_responder.sv
// Scoreboard bench: two responders (short and long latency) share one randomized request stream.
module tb_sram_like_responder;
  localparam int L0 = 2;
  localparam int D0 = 4;
  localparam int L1 = 8;
  localparam int D1 = 4;

  typedef struct {
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [3:0]  wstrb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        aok [2];
  logic        dok [2];
  logic [31:0] rd  [2];

  exp_t        expq [2][$];
  logic [31:0] mmem [2][1024];
  int          acc_cnt [2];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  int          pool [8] = '{0, 1, 2, 3, 4, 5, 'h3FF, 'h200};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_responder #(.ADDR_W(10), .LATENCY(L0), .DEPTH(D0)) dut0 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(aok[0]), .data_ok(dok[0]), .rdata(rd[0])
  );

  sram_like_responder #(.ADDR_W(10), .LATENCY(L1), .DEPTH(D1)) dut1 (
    .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
    .addr(addr), .wdata(wdata), .addr_ok(aok[1]), .data_ok(dok[1]), .rdata(rd[1])
  );

  function automatic int lat_of(int i);
    return (i == 0) ? L0 : L1;
  endfunction

  function automatic int dep_of(int i);
    return (i == 0) ? D0 : D1;
  endfunction

  task automatic check(int i, string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s [dut%0d] cycle %0d: got %h expected %h", nm, i, cyc, act, exp);
  endtask

  // Monitor: compares each cycle's outputs against the expectation queues.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        check(i, "addr_ok_in_reset", 32'(aok[i]), 32'h0);
        check(i, "data_ok_in_reset", 32'(dok[i]), 32'h0);
        check(i, "rdata_in_reset", rd[i], 32'h0);
      end else begin
`ifdef SRAM_LIKE_RANDOM_DELAY_EN
        if (expq[i].size() >= dep_of(i)) check(i, "addr_ok_full", 32'(aok[i]), 32'h0);
        if (dok[i] && expq[i].size() == 0) check(i, "spurious_data_ok", 32'(dok[i]), 32'h0);
        if (dok[i] && expq[i].size() > 0)
          check(i, "latency_min", 32'(cyc - expq[i][0].acc >= lat_of(i)), 32'h1);
`else
        check(i, "addr_ok", 32'(aok[i]), 32'(expq[i].size() < dep_of(i)));
        check(i, "data_ok", 32'(dok[i]),
              32'(expq[i].size() > 0 && (cyc - expq[i][0].acc) == lat_of(i)));
`endif
        if (dok[i] && expq[i].size() > 0) begin
          check(i, "rdata", rd[i], expq[i][0].data);
          void'(expq[i].pop_front());
        end else begin
          check(i, "rdata_idle", rd[i], 32'h0);
        end
      end
    end
  end

  // One bus cycle of stimulus; accepted requests are pushed into the scoreboard.
  task automatic drive(bit r, bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d, bit rst);
    exp_t       e;
    logic [9:0] idx;
    @(posedge clk);
    #1;
    reset = rst; req = r; wr = w; wstrb = s; addr = a; wdata = d;
    size = 2'($urandom_range(0, 3));
    @(negedge clk);
    #1;
    idx = a[11:2];
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        expq[i].delete();
      end else if (r && aok[i]) begin
        acc_cnt[i]++;
        e.acc = cyc;
        if (w) begin
          e.data = 32'h0;
          for (int b = 0; b < 4; b++)
            if (s[b]) mmem[i][idx][8*b +: 8] = d[8*b +: 8];
        end else begin
          e.data = mmem[i][idx];
        end
        expq[i].push_back(e);
      end
    end
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain();
    int n = 0;
    while ((expq[0].size() + expq[1].size()) != 0 && n < 100) begin
      idle();
      n++;
    end
    check(0, "drain_timeout", 32'(expq[0].size() + expq[1].size()), 32'h0);
  endtask

  task automatic single(bit w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
    drive(1'b1, w, s, a, d, 1'b0);
    drain();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    return (r & 32'hFFFF_F003) | (32'(pool[$urandom_range(0, 7)]) << 2);
  endfunction

  initial begin
    int a0;
    int a1;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    repeat (3) drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    idle();

    for (int k = 0; k < 8; k++) single(1'b1, 4'hF, 32'(pool[k]) << 2, $urandom);

    single(1'b1, 4'hF, 32'h1C00_0010, 32'hDEAD_BEEF);
    single(1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    single(1'b1, 4'h1, 32'h1C00_0010, 32'h0000_00AA);
    single(1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    single(1'b1, 4'h0, 32'h1C00_0010, 32'hFFFF_FFFF);
    single(1'b0, 4'h0, 32'h1C00_0010, 32'h0);
    single(1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678);
    single(1'b0, 4'h0, 32'h0000_0000, 32'h0);

    // Held request stream: the long-latency responder must fill and stall.
    a0 = acc_cnt[0];
    a1 = acc_cnt[1];
    repeat (6) drive(1'b1, 1'b0, 4'h0, rand_addr(), 32'h0, 1'b0);
`ifndef SRAM_LIKE_RANDOM_DELAY_EN
    check(0, "full_q_accepts", 32'(acc_cnt[0] - a0), 32'd6);
    check(1, "full_q_accepts", 32'(acc_cnt[1] - a1), 32'd4);
`endif
    drain();

    a0 = acc_cnt[0];
    repeat (10) drive(1'b1, 1'b0, 4'h0, rand_addr(), 32'h0, 1'b0);
`ifndef SRAM_LIKE_RANDOM_DELAY_EN
    check(0, "throughput_accepts", 32'(acc_cnt[0] - a0), 32'd10);
`endif
    drain();

    repeat (3) drive(1'b1, 1'b0, 4'h0, rand_addr(), 32'h0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
    repeat (20) idle();
    single(1'b0, 4'h0, 32'h1C00_0010, 32'h0);

    for (int k = 0; k < 400; k++)
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 4'($urandom),
            rand_addr(), $urandom, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
